// File: rtl/conv2_sram_reader.sv
// conv2_sram_reader
// Burst reader that streams words out of a single-port SRAM to the PE array.
// A start pulse latches base_addr/len (len clamped to DP). Read addresses run
// base_addr, base_addr+1, ... and wrap from DP-1 back to 0. Read data lands
// in a 2-entry FIFO and leaves through a valid/ready stream. Reads are
// credit-limited, so buffered words plus outstanding reads never exceed two.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr, len   burst request (sampled only in IDLE)
//   busy, done              burst in progress / one-cycle completion pulse
//   sram_cs .. sram_din     SRAM port (read-only use: we, wem, din held 0)
//   sram_dout               SRAM read data, valid the cycle after a read
//   out_valid, out_ready,
//   out_data, out_last      output stream (out_last marks word len-1)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, throttled by FIFO credits
// DRAIN | all reads issued, waiting for the last beat to be taken
module conv2_sram_reader #(
    parameter int DP = 16,
    parameter int DW = 96,
    parameter int AW = 10,
    parameter int MW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [MW-1:0] sram_wem,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW:0]   rd_left;
    logic [AW:0]   len_eff;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    fifo_count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          pop;
    logic          issue;
    logic          last_issue;
    logic [2:0]    occ;

    assign pop        = out_valid & out_ready;
    // Slots that will be committed after this edge; a beat leaving this
    // cycle frees its slot in time for a new read.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == RUN) && (occ < 3'd2);
    assign last_issue = issue && (rd_left == (AW+1)'(1));
    assign len_eff    = (len > (AW+1)'(DP)) ? (AW+1)'(DP) : len;

    assign sram_cs   = issue;
    assign sram_we   = 1'b0;
    assign sram_wem  = '0;
    assign sram_din  = '0;
    assign sram_addr = addr_q;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            rd_left       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_count    <= 2'd0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_last     <= 2'b00;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= last_issue;

            if (issue) begin
                addr_q  <= (addr_q == AW'(DP-1)) ? '0 : addr_q + 1'b1;
                rd_left <= rd_left - 1'b1;
            end

            // sram_dout belongs to the read issued last cycle
            if (inflight) begin
                fifo_data[wr_ptr] <= sram_dout;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        rd_left <= len_eff;
                        if (len_eff == '0) done  <= 1'b1;
                        else               state <= RUN;
                    end
                end
                RUN: begin
                    if (last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_sram_reader.sv
module tb_conv2_sram_reader;
    localparam int DP = 16;
    localparam int DW = 96;
    localparam int AW = 10;
    localparam int MW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done;
    logic          sram_cs, sram_we;
    logic [MW-1:0] sram_wem;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    conv2_sram_reader #(.DP(DP), .DW(DW), .AW(AW), .MW(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_wem(sram_wem), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // SRAM preloaded with mem[k] = k; data appears the cycle after the read
    always @(posedge clk) begin
        if (sram_cs && !sram_we) sram_dout <= DW'(sram_addr);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         base;
        int         ln;
        logic [7:0] rpat;       // out_ready in cycle c is rpat[c%8]
        bit         restart;    // pulse start again in cycle 3
        int         exp_beats;
        int         exp_fv;     // first out_valid cycle, -1 = not checked
        int         exp_done;   // done cycle, -1 = not checked
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int beats = 0, reads = 0, done_cnt = 0, done_c = -1, fv = -1, stray = 0, eff, occ;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        eff = (v.ln > DP) ? DP : v.ln;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(v.base); len = (AW+1)'(v.ln); out_ready = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            start = v.restart && (c == 3);
            if (start) begin base_addr = AW'(9); len = (AW+1)'(2); end
            out_ready = v.rpat[c%8];
            #1;
            if (c == 1) check({tag, "_busy_c1"}, busy, eff > 0);
            if (done) begin
                done_cnt++;
                done_c = c;
                check({tag, "_busy_at_done"}, busy, 0);
            end
            if (prev_stall)
                check({tag, "_stall_hold"}, {out_valid, out_data, out_last}, {1'b1, prev_data, prev_last});
            if (out_valid) begin
                if (fv < 0) fv = c;
                if (out_ready) begin
                    check({tag, "_data"}, out_data, (v.base + beats) % DP);
                    check({tag, "_last"}, out_last, beats == eff - 1);
                    beats++;
                end
            end
            if (sram_cs) begin
                check({tag, "_addr"}, sram_addr, (v.base + reads) % DP);
                check({tag, "_sram_ctl"}, {sram_we, sram_wem, sram_din}, 0);
                reads++;
                occ = reads - beats;
                check({tag, "_occupancy"}, occ <= 2, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done_c >= 0 && c > done_c) begin
                if (out_valid || sram_cs || busy) stray++;
                if (c >= done_c + 3) break;
            end
        end
        start = 1'b0;
        check({tag, "_beats"}, beats, v.exp_beats);
        check({tag, "_reads"}, reads, v.exp_beats);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_after_done"}, stray, 0);
        if (v.exp_fv >= 0)   check({tag, "_first_valid"}, fv, v.exp_fv);
        if (v.exp_done >= 0) check({tag, "_done_cycle"}, done_c, v.exp_done);
    endtask

    vec_t vecs [8];
    int   beats_mid;
    int   stray_rst;

    initial begin
        vecs[0] = '{0,  4,  8'hFF,         1'b0, 4,  3, 7};
        vecs[1] = '{14, 4,  8'hFF,         1'b0, 4,  3, 7};
        vecs[2] = '{2,  6,  8'b0100_1001,  1'b0, 6,  3, -1};
        vecs[3] = '{4,  0,  8'hFF,         1'b0, 0, -1, 1};
        vecs[4] = '{3,  20, 8'hFF,         1'b0, 16, 3, 19};
        vecs[5] = '{1,  8,  8'hFF,         1'b1, 8,  3, 11};
        vecs[6] = '{7,  5,  8'hAA,         1'b0, 5,  3, -1};
        vecs[7] = '{15, 1,  8'hFF,         1'b0, 1,  3, 4};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sram_cs", sram_cs, 0);
        check("rst_sram_addr", sram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the third beat of a len=8 burst is on the stream
        beats_mid = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; len = (AW+1)'(8); out_ready = 1'b1;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (out_valid && out_ready) beats_mid++;
            if (beats_mid == 3) break;
        end
        check("mid_third_beat_seen", beats_mid, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {busy, done, out_valid, out_last, sram_cs, sram_addr, out_data}, 0);
        @(posedge clk); #1;
        check("mid_rst_outputs_held", {busy, done, out_valid, out_last, sram_cs, sram_addr, out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            if (out_valid || sram_cs || busy || done) stray_rst++;
        end
        check("post_rst_quiet", stray_rst, 0);
        run_vec('{5, 2, 8'hFF, 1'b0, 2, 3, 5}, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
